bm_decode_accum: RTL and testbench

- Sequential bitmatrix decode engine for reconstructing one lost data chunk from K surviving chunks.
- Each surviving chunk (W packets) arrives with its W x W sub-block of the inverted decode bitmatrix over a valid/ready stream.
- The block multiplies the chunk by the sub-block in GF(2) and XOR-accumulates the products.
- After K beats it presents the reconstructed chunk (W packets) on a valid/ready output. It is the decode-side counterpart of the encoder's bitmatrix multiply path.

---
 rtl/bm_decode_accum_if.sv | 24 ++
 rtl/bm_decode_accum.sv | 93 +++++++++
 tb/tb_bm_decode_accum.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bm_decode_accum_if.sv
// Stream bundle for the bitmatrix decode engine: chunk/bitmatrix input beats and
// reconstructed-chunk output, each with a valid/ready handshake.
interface bm_decode_accum_if #(
   parameter int unsigned W             = 4,
   parameter int unsigned PACKET_LENGTH = 2
);
   logic                               in_valid;
   logic                               in_ready;
   logic [W-1:0][W-1:0]                bitmatrix_cols;
   logic [W-1:0][PACKET_LENGTH-1:0]    data_packet;
   logic                               out_valid;
   logic                               out_ready;
   logic [W-1:0][PACKET_LENGTH-1:0]    out_packet;

   modport master (
      output in_valid, bitmatrix_cols, data_packet, out_ready,
      input  in_ready, out_valid, out_packet
   );

   modport slave (
      input  in_valid, bitmatrix_cols, data_packet, out_ready,
      output in_ready, out_valid, out_packet
   );
endinterface

// File: rtl/bm_decode_accum.sv
// Sequential GF(2) bitmatrix decode: XOR-accumulates K chunk x sub-block products and
// presents the reconstructed chunk on a valid/ready output.
module bm_decode_accum #(
   parameter int unsigned K             = 2,
   parameter int unsigned W             = 4,
   parameter int unsigned PACKET_LENGTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   bm_decode_accum_if.slave     bus
);
   localparam int unsigned CntW = $clog2(K + 1);

   typedef logic [W-1:0][PACKET_LENGTH-1:0] chunk_t;
   typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   chunk_t            acc_q, acc_d;
   chunk_t            out_q, out_d;
   chunk_t            contrib;
   logic              in_ready_c;
   logic              out_valid_c;

   // Output packet j is the XOR of the input packets selected by bitmatrix word j.
   always_comb begin
      contrib = '0;
      for (int unsigned j = 0; j < W; j++) begin
         for (int unsigned i = 0; i < W; i++) begin
            contrib[j] = contrib[j] ^
                         (bus.data_packet[i] & {PACKET_LENGTH{bus.bitmatrix_cols[j][i]}});
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_d       = out_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StAccum;
               cnt_d   = '0;
               acc_d   = '0;
            end
         end
         StAccum: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               acc_d = acc_q ^ contrib;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntW'(K - 1)) begin
                  // Capture the final sum including this beat so it is held through OUT.
                  state_d = StOut;
                  out_d   = acc_q ^ contrib;
               end
            end
         end
         StOut: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.out_packet = out_q;
   assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_bm_decode_accum.sv
// Randomized self-checking bench for bm_decode_accum against a GF(2) matrix-product model.
module tb_bm_decode_accum;
   localparam int unsigned K  = 2;
   localparam int unsigned W  = 4;
   localparam int unsigned PL = 2;

   typedef logic [W-1:0][W-1:0]  cols_t;
   typedef logic [W-1:0][PL-1:0] pkt_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   bm_decode_accum_if #(.W(W), .PACKET_LENGTH(PL)) bus ();

   bm_decode_accum #(.K(K), .W(W), .PACKET_LENGTH(PL)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reconstructed packet j = XOR of data packets i whose bit is set in word j.
   function automatic pkt_t gf2_mul(input cols_t c, input pkt_t d);
      pkt_t r = '0;
      for (int j = 0; j < int'(W); j++)
         for (int i = 0; i < int'(W); i++)
            if (c[j][i]) r[j] = r[j] ^ d[i];
      return r;
   endfunction

   task automatic rand_inputs();
      bus.bitmatrix_cols = cols_t'($urandom);
      bus.data_packet    = pkt_t'($urandom);
   endtask

   task automatic run_decode(input cols_t c[K], input pkt_t d[K], input bit gaps,
                             input int unsigned stall, output pkt_t got);
      pkt_t exp = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("accum_in_ready", bus.in_ready, 1);
      check_eq("accum_busy", busy, 1);
      for (int k = 0; k < int'(K); k++) begin
         if (gaps && k > 0) begin
            repeat (2) begin
               bus.in_valid = 1'b0;
               rand_inputs();
               start = 1'b1;
               tick();
               start = 1'b0;
               check_eq("gap_in_ready", bus.in_ready, 1);
            end
         end
         bus.in_valid       = 1'b1;
         bus.bitmatrix_cols = c[k];
         bus.data_packet    = d[k];
         exp                = exp ^ gf2_mul(c[k], d[k]);
         tick();
         bus.in_valid = 1'b0;
         if (k < int'(K) - 1) check_eq("mid_out_valid", bus.out_valid, 0);
      end
      check_eq("out_valid_latency", bus.out_valid, 1);
      check_eq("out_packet", bus.out_packet, exp);
      got = bus.out_packet;
      for (int unsigned s = 0; s < stall; s++) begin
         bus.in_valid = 1'b1;
         rand_inputs();
         start = 1'($urandom);
         tick();
         check_eq("bp_out_valid", bus.out_valid, 1);
         check_eq("bp_in_ready", bus.in_ready, 0);
         check_eq("bp_out_packet", bus.out_packet, exp);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      start         = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      start         = 1'b0;
      check_eq("done_out_valid", bus.out_valid, 0);
      check_eq("done_busy", busy, 0);
      check_eq("done_out_packet", bus.out_packet, exp);
   endtask

   initial begin
      cols_t c[K];
      pkt_t  d[K];
      pkt_t  got;

      rst           = 1'b1;
      start         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rand_inputs();
      repeat (3) begin
         rand_inputs();
         bus.in_valid  = 1'($urandom);
         bus.out_ready = 1'($urandom);
         start         = 1'($urandom);
         tick();
      end
      check_eq("rst_in_ready", bus.in_ready, 0);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_out_packet", bus.out_packet, 0);
      rst           = 1'b0;
      start         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      check_eq("idle_in_ready", bus.in_ready, 0);

      // Identity then all-ones: {1,2,3,0} ^ {3,3,3,3} = {2,1,0,3}.
      c[0] = '0;
      c[0][0] = 4'h1; c[0][1] = 4'h2; c[0][2] = 4'h4; c[0][3] = 4'h8;
      d[0] = '0;
      d[0][0] = 2'd1; d[0][1] = 2'd2; d[0][2] = 2'd3; d[0][3] = 2'd0;
      c[1] = '1;
      d[1] = '0;
      d[1][0] = 2'd1; d[1][1] = 2'd2;
      run_decode(c, d, 1'b0, 5, got);
      check_eq("directed", got, 64'hC6);
      run_decode(c, d, 1'b1, 0, got);
      check_eq("directed_gaps", got, 64'hC6);

      for (int k = 0; k < int'(K); k++) begin
         c[k] = '0;
         d[k] = pkt_t'($urandom);
      end
      run_decode(c, d, 1'b0, 1, got);
      check_eq("zero_matrix", got, 0);

      start = 1'b1;
      tick();
      start              = 1'b0;
      bus.in_valid       = 1'b1;
      rand_inputs();
      tick();
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_in_ready", bus.in_ready, 0);
      check_eq("midrst_out_valid", bus.out_valid, 0);
      check_eq("midrst_out_packet", bus.out_packet, 0);
      c[0] = '0;
      c[0][0] = 4'h1; c[0][1] = 4'h2; c[0][2] = 4'h4; c[0][3] = 4'h8;
      d[0] = '0;
      d[0][0] = 2'd1; d[0][1] = 2'd2; d[0][2] = 2'd3; d[0][3] = 2'd0;
      c[1] = '1;
      d[1] = '0;
      d[1][0] = 2'd1; d[1][1] = 2'd2;
      run_decode(c, d, 1'b0, 0, got);
      check_eq("post_rst_directed", got, 64'hC6);

      // Back-to-back random decodes; each run restarts the cycle after returning to IDLE.
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < int'(K); k++) begin
            c[k] = cols_t'($urandom);
            d[k] = pkt_t'($urandom);
         end
         run_decode(c, d, 1'($urandom), $urandom_range(0, 3), got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
